// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default widths and operand indexing for the conv MAC scheduler.
package conv_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_STORE = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;
    localparam int RES_W_DEF  = 8;
    localparam int N_POS      = 4;
    localparam int N_TAP      = 9;
    // Element of the 4x4 operand under kernel tap (i,j) at output position (r,c).
    function automatic logic [3:0] a_idx(input logic [1:0] pos, input logic [3:0] tap);
        int r = int'(pos[1]) + int'(tap) / 3;
        int c = int'(pos[0]) + int'(tap) % 3;
        return 4'(r * 4 + c);
    endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered unsigned multiply-accumulate with clear and enable.
module conv_mac import conv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic [2*DATA_W-1:0] prod;
    assign prod = a * b;
    always_ff @(posedge clk) begin
        if (reset || clr) acc <= '0;
        else if (en) acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: 2x2 valid convolution of 4x4 A by 3x3 B on one shared MAC, results streamed row-major.
// Define CONV_SAT_EN to saturate stored results instead of truncating them.
module conv_mac_scheduler import conv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [16*DATA_W-1:0] a_flat,
    input  logic [9*DATA_W-1:0]  b_flat,
    output logic [RES_W-1:0]     result,
    output logic                 result_valid,
    output logic [1:0]           result_idx,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           current_state
);
    state_t state, state_nx;
    logic run_d;
    logic [16*DATA_W-1:0] a_reg;
    logic [9*DATA_W-1:0] b_reg;
    logic [3:0] tap;
    logic [1:0] pos;
    logic [RES_W-1:0] res_buf [N_POS];
    logic [ACC_W-1:0] acc;
    logic [RES_W-1:0] acc_red;
    logic [DATA_W-1:0] op_a, op_b;
    logic mac_clr, mac_en, last_tap;

    assign op_a     = a_reg[int'(a_idx(pos, tap)) * DATA_W +: DATA_W];
    assign op_b     = b_reg[int'(tap) * DATA_W +: DATA_W];
    assign mac_clr  = state == S_LOAD || state == S_STORE;
    assign mac_en   = state == S_MAC;
    assign last_tap = tap == 4'(N_TAP - 1);
`ifdef CONV_SAT_EN
    assign acc_red = |acc[ACC_W-1:RES_W] ? {RES_W{1'b1}} : acc[RES_W-1:0];
`else
    assign acc_red = acc[RES_W-1:0];
`endif

    conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .reset(reset), .clr(mac_clr), .en(mac_en), .a(op_a), .b(op_b), .acc(acc)
    );

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = (run && !run_d) ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = S_MAC;
            S_MAC:   state_nx = last_tap ? S_STORE : S_MAC;
            S_STORE: state_nx = (pos == 2'd3) ? S_OUT : S_MAC;
            S_OUT:   state_nx = (pos == 2'd3) ? S_DONE : S_OUT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs mirror the state being executed on each edge, so they trail the internal state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            run_d         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            tap           <= '0;
            pos           <= '0;
            res_buf       <= '{default: '0};
            result        <= '0;
            result_valid  <= 1'b0;
            result_idx    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            current_state <= '0;
        end else begin
            state <= state_nx;
            run_d <= run;
            if (state == S_LOAD) begin
                a_reg   <= a_flat;
                b_reg   <= b_flat;
                res_buf <= '{default: '0};
            end
            if (state == S_STORE) res_buf[pos] <= acc_red;
            tap           <= (state == S_MAC && !last_tap) ? tap + 4'd1 : 4'd0;
            pos           <= (state == S_STORE || state == S_OUT) ? pos + 2'd1 : (state == S_LOAD ? 2'd0 : pos);
            result        <= (state == S_OUT) ? res_buf[pos] : '0;
            result_valid  <= state == S_OUT;
            result_idx    <= (state == S_OUT) ? pos : 2'd0;
            busy          <= state != S_IDLE;
            done          <= state == S_DONE;
            current_state <= state;
        end
    end
endmodule

// File: tb/tb_conv_mac_scheduler.sv
// tb_conv_mac_scheduler: directed and randomized jobs checked every cycle against a job-timeline model.
module tb_conv_mac_scheduler;
    logic clk = 1'b0;
    logic reset, run;
    logic [127:0] a_flat;
    logic [71:0] b_flat;
    logic [7:0] result;
    logic result_valid, busy, done;
    logic [1:0] result_idx;
    logic [2:0] current_state;

    always #5 clk = ~clk;

    conv_mac_scheduler dut (
        .clk(clk), .reset(reset), .run(run), .a_flat(a_flat), .b_flat(b_flat),
        .result(result), .result_valid(result_valid), .result_idx(result_idx),
        .busy(busy), .done(done), .current_state(current_state)
    );

    int n_cmp = 0, n_bad = 0, n_valid = 0, n_done = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int conv_ref(input logic [127:0] a, input logic [71:0] b, input int p);
        int r = p / 2, c = p % 2, s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(a[((r + i) * 4 + c + j) * 8 +: 8]) * int'(b[(i * 3 + j) * 8 +: 8]);
`ifdef CONV_SAT_EN
        return s > 255 ? 255 : s;
`else
        return s % 256;
`endif
    endfunction

    // Visible state code d cycles after the sampled run edge.
    function automatic int exp_state(input int d);
        if (d == 0 || d > 46) return 0;
        if (d == 1) return 1;
        if (d <= 41) return ((d - 1) % 10 == 0) ? 3 : 2;
        if (d <= 45) return 4;
        return 5;
    endfunction

    logic m_active = 1'b0, m_run_prev = 1'b0;
    int m_d = 0;
    int m_exp [4];

    always @(posedge clk) begin : model
        logic act;
        int d;
        act = m_active;
        d = m_d;
        if (reset) begin
            act = 1'b0;
            d = 0;
        end else begin
            if (act) begin
                d++;
                if (d == 1) for (int p = 0; p < 4; p++) m_exp[p] <= conv_ref(a_flat, b_flat, p);
                if (d == 47) act = 1'b0;
            end
            if (!act && run && !m_run_prev) begin
                act = 1'b1;
                d = 0;
            end
        end
        m_active <= act;
        m_d <= d;
        m_run_prev <= reset ? 1'b0 : run;
    end

    always @(negedge clk) begin : compare
        int es;
        if (chk_en) begin
            es = m_active ? exp_state(m_d) : 0;
            chk("state", int'(current_state), es);
            chk("busy", int'(busy), int'(es != 0));
            chk("done", int'(done), int'(es == 5));
            chk("valid", int'(result_valid), int'(es == 4));
            if (es == 4) begin
                chk("idx", int'(result_idx), m_d - 42);
                chk("result", int'(result), m_exp[m_d - 42]);
            end
            if (result_valid) n_valid++;
            if (done) n_done++;
        end
    end

    task automatic set_vec();
        int av [16] = '{8,6,10,10, 9,1,10,5, 1,3,1,8, 10,6,10,1};
        int bv [9] = '{2,5,5, 5,3,5, 4,0,4};
        for (int i = 0; i < 16; i++) a_flat[i*8 +: 8] = 8'(av[i]);
        for (int i = 0; i < 9; i++) b_flat[i*8 +: 8] = 8'(bv[i]);
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", int'(seen), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pin_vec(input string tag);
        chk({tag, "_c11"}, m_exp[0], 202);
        chk({tag, "_c12"}, m_exp[1], 216);
        chk({tag, "_c21"}, m_exp[2], 172);
        chk({tag, "_c22"}, m_exp[3], 163);
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        a_flat = '0;
        b_flat = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(current_state), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);

        set_vec();
        n_valid = 0; n_done = 0;
        pulse_run();
        wait_done();
        pin_vec("vec");
        chk("vec_valids", n_valid, 4);
        chk("vec_dones", n_done, 1);

        a_flat = '1;
        b_flat = '1;
        pulse_run();
        wait_done();
`ifdef CONV_SAT_EN
        for (int p = 0; p < 4; p++) chk("max_res", m_exp[p], 255);
`else
        for (int p = 0; p < 4; p++) chk("max_res", m_exp[p], 9);
`endif

        set_vec();
        n_valid = 0; n_done = 0;
        @(negedge clk) run = 1'b1;
        repeat (20) @(negedge clk);
        run = 1'b0;
        @(negedge clk) run = 1'b1;
        repeat (6) @(negedge clk);
        run = 1'b0;
        @(negedge clk) run = 1'b1;
        wait_done();
        repeat (5) @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_valids", n_valid, 4);
        chk("hold_dones", n_done, 1);

        n_valid = 0; n_done = 0;
        pulse_run();
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("abort_state", int'(current_state), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_idx", int'(result_idx), 0);
        chk("abort_valid", int'(result_valid), 0);
        chk("abort_done", int'(done), 0);
        repeat (50) @(negedge clk);
        chk("abort_valids", n_valid, 0);
        reset = 1'b1;
        run = 1'b1;
        @(negedge clk) reset = 1'b0;
        wait_done();
        run = 1'b0;
        pin_vec("rerun");
        chk("rerun_valids", n_valid, 4);

        pulse_run();
        repeat (3) @(negedge clk);
        a_flat = '0;
        wait_done();
        pin_vec("late_a");

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 16; i++) a_flat[i*8 +: 8] = 8'($urandom);
                for (int i = 0; i < 9; i++) b_flat[i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            end
        end
        reset = 1'b0;
        run = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_mac_scheduler.md
# conv_mac_scheduler

Sequencer that computes the 2×2 valid convolution of a 4×4 operand matrix A with a 3×3 kernel B on one shared multiply-accumulate unit. On a `run` rising edge it latches both operands, walks the 4 output positions × 9 kernel taps, buffers the four results, then streams them out in row-major order with a valid strobe and a state code for the display path. It sits between the operand registers and the display logic, in place of a dedicated per-output datapath.

## Interface
- `DATA_W`, 8, operand element width (unsigned)
- `ACC_W`, 20, accumulator width; holds 9 × (2^DATA_W−1)^2 without overflow
- `RES_W`, 8, width of the streamed result
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  start request; only a 0→1 transition is acted on
- `a_flat`  in  16·DATA_W  A row-major; a11 at [DATA_W−1:0], a44 at top
- `b_flat`  in  9·DATA_W  B row-major; b11 at [DATA_W−1:0], b33 at top
- `result`  out  RES_W  current streamed result
- `result_valid`  out  1  `result` is valid this cycle
- `result_idx`  out  2  0=c11, 1=c12, 2=c21, 3=c22
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last result
- `current_state`  out  3  state encoding below

## Operation
- States: IDLE=0, LOAD=1, MAC=2, STORE=3, OUT=4, DONE=5; 6, 7 unused, decode to IDLE.
- IDLE: `run_d` registers `run` every cycle; `run & ~run_d` → LOAD. Level-high `run` never retriggers.
- LOAD: latch `a_flat`/`b_flat` into internal registers; clear accumulator, tap=0, pos=0 → MAC.
- MAC: accumulate a[r+i][c+j]·b[i][j], pos=(r,c) row-major, tap=(i,j) row-major; tap 8 → STORE.
- STORE: write accumulator (reduced per Configuration) to buffer[pos]; clear acc and tap; pos<3 → MAC, else pos=0 → OUT.
- OUT: one buffer entry per cycle, idx 0..3; after idx 3 → DONE.
- DONE: `done`=1 for one cycle → IDLE. Buffer holds its values until next LOAD or reset.
- `run` edges while `busy` are ignored; operand changes after LOAD have no effect.
- Multiply DATA_W×DATA_W unsigned to 2·DATA_W, zero-extend to ACC_W; accumulate unsigned.

## Timing
- Reset values: `result`=0, `result_valid`=0, `result_idx`=0, `busy`=0, `done`=0, `current_state`=0; acc, counters, buffer, `run_d` = 0.
- Edge T samples the run rising edge; LOAD at T+1; MAC T+2..T+10 for c11; STORE T+11; each later position +10 edges (STOREs at T+21, T+31, T+41).
- All outputs registered: `result_valid` high for exactly 4 consecutive cycles following edges T+42..T+45, idx 0,1,2,3.
- `done` high for the cycle after edge T+46; IDLE after T+47. Total 47 cycles, run edge to IDLE.
- `reset` asserted in any state: next edge forces all reset values, aborts the job; no partial results emitted.
- `reset` and a `run` edge in the same cycle: reset wins; `run_d` is cleared, so `run` still high after reset counts as a new edge.

## Configuration
- `CONV_SAT_EN` defined: STORE writes min(acc, 2^RES_W−1) — saturating.
- Not defined: STORE writes acc[RES_W−1:0] — wrap-around truncation.

## Structure
- `conv_pkg`: state encoding constants, default DATA_W/ACC_W/RES_W, N_POS=4, N_TAP=9, operand index helper.
- Sub-module `conv_mac`: registered multiply-accumulate with `clr` and `en`; scheduler owns FSM, counters, operand mux, result buffer.

## Test plan
- A rows {8,6,10,10},{9,1,10,5},{1,3,1,8},{10,6,10,1}; B rows {2,5,5},{5,3,5},{4,0,4}; pulse run → results 202, 216, 172, 163 with idx 0..3 on 4 consecutive cycles, first valid 42 cycles after the sampled edge; `done` one cycle later.
- A and B all 255 → without `CONV_SAT_EN` all four results 9; with it all 255.
- Hold `run` high through whole job, plus extra run pulses while busy → exactly one job, 4 valids, one `done`.
- Assert `reset` mid-MAC of c12 → next cycle state 0, all outputs 0, no `result_valid`; new run pulse reproduces 202/216/172/163.
- Change `a_flat` to all zero two cycles after LOAD → results unchanged (202, 216, 172, 163).
- Track `current_state` over a job → 0,1,2×9,3,(2×9,3)×3,4×4,5,0; `busy` high exactly while nonzero.
